click_decoder: RTL and testbench
================================

CLICK_DECODER -- requirements
Module: click_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Parameter GAP, default 25000000, SHALL be the inter-press window in clk cycles; legal range 2 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 25, SHALL be the window timer width in bits.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 press  input  1  single-cycle clean press pulse from the button conditioning stage; a multi-cycle high counts once per cycle high.
REQ-007 click1  output  1  one-cycle pulse: a sequence of exactly one press completed.
REQ-008 click2  output  1  one-cycle pulse: a sequence of exactly two presses completed.
REQ-009 click3  output  1  one-cycle pulse: a sequence of three presses completed.
REQ-010 busy  output  1  high whenever a sequence is in progress or being reported (state != IDLE).
REQ-011 last_count  output  2  count of the most recently reported sequence (1..3); holds until the next report.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and EMIT, plus a 2-bit press count cnt and a CNT_W-bit timer tmr.
REQ-013 IDLE, press=1: next state WAIT, cnt=1, tmr=0; press=0: stay in IDLE.
REQ-014 WAIT, press=1, cnt<2: cnt+1, tmr=0, stay in WAIT (the window restarts from each press).
REQ-015 WAIT, press=1, cnt=2: cnt=3, next state EMIT immediately; no window wait is applied to the third press.
REQ-016 WAIT, press=0, tmr<GAP-1: tmr+1.
REQ-017 WAIT, press=0, tmr=GAP-1: next state EMIT.
REQ-018 Single-click latency: EMIT SHALL be entered on the GAP-th rising edge after the edge that captured the last press.
REQ-019 In EMIT, exactly one of click1/click2/click3 SHALL be high, selected by cnt, for exactly one cycle.
REQ-020 In EMIT, last_count SHALL be loaded with cnt on the same edge that enters EMIT.
REQ-021 Outputs click1..3 SHALL be registered (state-decoded Moore outputs); press SHALL never combinationally reach any output.
REQ-022 EMIT, press=0: next state IDLE, cnt=0, tmr=0.
REQ-023 EMIT, press=1: next state WAIT, cnt=1, tmr=0; the press starts a new sequence and is never lost.
REQ-024 cnt SHALL never exceed 3; tmr SHALL never exceed GAP-1 and SHALL not wrap.
REQ-025 busy SHALL be low only in IDLE.

Reset
REQ-026 While rst=1: state=IDLE, cnt=0, tmr=0, click1=click2=click3=0, last_count=0, busy=0, independent of clk.
REQ-027 An rst assertion mid-sequence (WAIT or EMIT) SHALL discard the sequence; no click pulse is produced for it after release.
REQ-028 The first rising edge after rst deasserts SHALL evaluate the IDLE transitions normally, including a press present on that edge.

Verification (GAP=4; edge n = nth rising clk edge after reset release)
REQ-029 Single: press high at edge 1 only -> busy=1 from edge 1; click1=1 for one cycle after edge 5; last_count=1; busy=0 after edge 6.
REQ-030 Double: presses at edges 1 and 3 -> click2=1 for one cycle after edge 7; click1 and click3 never assert.
REQ-031 Triple: presses at edges 1, 2 and 3 -> click3=1 for one cycle after edge 3; back to IDLE after edge 4; last_count=3.
REQ-032 Window boundary: presses at edges 1 and 5 -> click1 after edge 5 reports the first press; the press at edge 5 is accepted as a new sequence; click1 again after edge 9.
REQ-033 Reset mid-operation: press at edge 1, rst pulsed between edges 2 and 3 -> all outputs 0 immediately; no click pulse within 10 cycles.
REQ-034 Held press: press held high across edges 1-3 -> treated as three presses; click3 after edge 3.

Source files
------------

// File: rtl/click_decoder.sv
// Counts button presses that fall within a GAP-cycle window of each other
// and reports completed single/double/triple sequences as one-cycle pulses.
module click_decoder #(
   parameter int GAP   = 25000000,
   parameter int CNT_W = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       press,
   output logic       click1,
   output logic       click2,
   output logic       click3,
   output logic       busy,
   output logic [1:0] last_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EMIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(GAP - 1);

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic             report_s;
   logic [1:0]       report_cnt_s;
   logic             click1_q, click2_q, click3_q;
   logic             busy_q;
   logic [1:0]       last_count_q;

   // Next-state logic; a press landing on the closing edge of the window
   // reports the old sequence and opens a new one in the same cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tmr_d        = tmr_q;
      report_s     = 1'b0;
      report_cnt_s = cnt_q;
      case (state_q)
         IDLE: begin
            if (press) begin
               state_d = WAIT;
               cnt_d   = 2'd1;
               tmr_d   = {CNT_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (tmr_q >= TMR_LAST) begin
               report_s     = 1'b1;
               report_cnt_s = cnt_q;
               if (press) begin
                  state_d = WAIT;
                  cnt_d   = 2'd1;
                  tmr_d   = {CNT_W{1'b0}};
               end else begin
                  state_d = EMIT;
               end
            end else if (press) begin
               if (cnt_q >= 2'd2) begin
                  state_d      = EMIT;
                  cnt_d        = 2'd3;
                  report_s     = 1'b1;
                  report_cnt_s = 2'd3;
               end else begin
                  cnt_d = cnt_q + 2'd1;
                  tmr_d = {CNT_W{1'b0}};
               end
            end else begin
               tmr_d = tmr_q + CNT_W'(1);
            end
         end
         EMIT: begin
            if (press) begin
               state_d = WAIT;
               cnt_d   = 2'd1;
               tmr_d   = {CNT_W{1'b0}};
            end else begin
               state_d = IDLE;
               cnt_d   = 2'd0;
               tmr_d   = {CNT_W{1'b0}};
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            tmr_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and registered Moore outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         tmr_q        <= {CNT_W{1'b0}};
         click1_q     <= 1'b0;
         click2_q     <= 1'b0;
         click3_q     <= 1'b0;
         busy_q       <= 1'b0;
         last_count_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         click1_q <= report_s && (report_cnt_s == 2'd1);
         click2_q <= report_s && (report_cnt_s == 2'd2);
         click3_q <= report_s && (report_cnt_s == 2'd3);
         busy_q   <= (state_d != IDLE);
         if (report_s) begin
            last_count_q <= report_cnt_s;
         end else begin
            last_count_q <= last_count_q;
         end
      end
   end

   assign click1     = click1_q;
   assign click2     = click2_q;
   assign click3     = click3_q;
   assign busy       = busy_q;
   assign last_count = last_count_q;

endmodule

// File: tb/tb_click_decoder.sv
// Scoreboard bench for click_decoder with GAP=4; edge n counts rising edges
// after reset release.
module tb_click_decoder;

   localparam int GAP   = 4;
   localparam int CNT_W = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       press;
   logic       click1, click2, click3, busy;
   logic [1:0] last_count;

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;

   typedef struct {
      int         at_edge;
      logic [2:0] clicks;
      logic [1:0] lc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   click_decoder #(.GAP(GAP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .press(press),
      .click1(click1), .click2(click2), .click3(click3),
      .busy(busy), .last_count(last_count)
   );

   task automatic apply_reset();
      rst = 1'b1;
      press = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      edge_n = 0;
      sb.delete();
   endtask

   task automatic step(input logic p);
      press = p;
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic test_reset();
      apply_reset();
      step(1'b1);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL reset_pre_busy got %b want 1", busy); end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({click3, click2, click1, busy, last_count} !== 6'b000000) begin
         n_err++;
         $display("FAIL reset_async_outputs got %b want 000000", {click3, click2, click1, busy, last_count});
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      exp_t e;
      apply_reset();
      sb.push_back('{5, 3'b001, 2'd1});
      for (int i = 1; i <= 12; i++) begin
         step(i == 1);
         if (i == 1 || i == 5) begin
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_hi edge %0d got %b want 1", i, busy); end
         end
         if (i == 6) begin
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_lo edge %0d got %b want 0", i, busy); end
         end
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL single_unexpected edge %0d clicks %b want none", edge_n, {click3, click2, click1});
            end else begin
               e = sb.pop_front();
               if (edge_n !== e.at_edge || {click3, click2, click1} !== e.clicks || last_count !== e.lc) begin
                  n_err++; $display("FAIL single_click got edge %0d clicks %b lc %0d want edge %0d clicks %b lc %0d",
                                    edge_n, {click3, click2, click1}, last_count, e.at_edge, e.clicks, e.lc);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL single_missing got %0d pending want 0", sb.size()); end
      n_cmp++;
      if (last_count !== 2'd1) begin n_err++; $display("FAIL single_lc_hold got %0d want 1", last_count); end
   endtask

   task automatic test_double();
      exp_t e;
      apply_reset();
      sb.push_back('{7, 3'b010, 2'd2});
      for (int i = 1; i <= 12; i++) begin
         step(i == 1 || i == 3);
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL double_unexpected edge %0d clicks %b want none", edge_n, {click3, click2, click1});
            end else begin
               e = sb.pop_front();
               if (edge_n !== e.at_edge || {click3, click2, click1} !== e.clicks || last_count !== e.lc) begin
                  n_err++; $display("FAIL double_click got edge %0d clicks %b lc %0d want edge %0d clicks %b lc %0d",
                                    edge_n, {click3, click2, click1}, last_count, e.at_edge, e.clicks, e.lc);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL double_missing got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_late_second();
      exp_t e;
      apply_reset();
      sb.push_back('{8, 3'b010, 2'd2});
      for (int i = 1; i <= 12; i++) begin
         step(i == 1 || i == 4);
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL late_unexpected edge %0d clicks %b want none", edge_n, {click3, click2, click1});
            end else begin
               e = sb.pop_front();
               if (edge_n !== e.at_edge || {click3, click2, click1} !== e.clicks || last_count !== e.lc) begin
                  n_err++; $display("FAIL late_click got edge %0d clicks %b lc %0d want edge %0d clicks %b lc %0d",
                                    edge_n, {click3, click2, click1}, last_count, e.at_edge, e.clicks, e.lc);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL late_missing got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_triple(input logic held);
      exp_t e;
      apply_reset();
      sb.push_back('{3, 3'b100, 2'd3});
      for (int i = 1; i <= 10; i++) begin
         step(i <= 3);
         if (i == 4) begin
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL triple_idle held=%0b got busy %b want 0", held, busy); end
         end
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL triple_unexpected held=%0b edge %0d clicks %b want none", held, edge_n, {click3, click2, click1});
            end else begin
               e = sb.pop_front();
               if (edge_n !== e.at_edge || {click3, click2, click1} !== e.clicks || last_count !== e.lc) begin
                  n_err++; $display("FAIL triple_click held=%0b got edge %0d clicks %b lc %0d want edge %0d clicks %b lc %0d",
                                    held, edge_n, {click3, click2, click1}, last_count, e.at_edge, e.clicks, e.lc);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL triple_missing held=%0b got %0d pending want 0", held, sb.size()); end
      n_cmp++;
      if (last_count !== 2'd3) begin n_err++; $display("FAIL triple_lc got %0d want 3", last_count); end
   endtask

   task automatic test_boundary();
      exp_t e;
      apply_reset();
      sb.push_back('{5, 3'b001, 2'd1});
      sb.push_back('{9, 3'b001, 2'd1});
      for (int i = 1; i <= 14; i++) begin
         step(i == 1 || i == 5);
         if (i == 6) begin
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL boundary_busy got %b want 1", busy); end
         end
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL boundary_unexpected edge %0d clicks %b want none", edge_n, {click3, click2, click1});
            end else begin
               e = sb.pop_front();
               if (edge_n !== e.at_edge || {click3, click2, click1} !== e.clicks || last_count !== e.lc) begin
                  n_err++; $display("FAIL boundary_click got edge %0d clicks %b lc %0d want edge %0d clicks %b lc %0d",
                                    edge_n, {click3, click2, click1}, last_count, e.at_edge, e.clicks, e.lc);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL boundary_missing got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      apply_reset();
      sb.push_back('{3, 3'b100, 2'd3});
      sb.push_back('{8, 3'b001, 2'd1});
      for (int i = 1; i <= 12; i++) begin
         step(i <= 4);
         if (i == 4) begin
            n_cmp++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
         end
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL b2b_unexpected edge %0d clicks %b want none", edge_n, {click3, click2, click1});
            end else begin
               e = sb.pop_front();
               if (edge_n !== e.at_edge || {click3, click2, click1} !== e.clicks || last_count !== e.lc) begin
                  n_err++; $display("FAIL b2b_click got edge %0d clicks %b lc %0d want edge %0d clicks %b lc %0d",
                                    edge_n, {click3, click2, click1}, last_count, e.at_edge, e.clicks, e.lc);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin n_err++; $display("FAIL b2b_missing got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      step(1'b1);
      step(1'b0);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({click3, click2, click1, busy, last_count} !== 6'b000000) begin
         n_err++;
         $display("FAIL midreset_outputs got %b want 000000", {click3, click2, click1, busy, last_count});
      end
      #2;
      rst = 1'b0;
      for (int i = 3; i <= 12; i++) begin
         step(1'b0);
         if ({click3, click2, click1} !== 3'b000) begin
            n_cmp++;
            n_err++;
            $display("FAIL midreset_click edge %0d got %b want 000", edge_n, {click3, click2, click1});
         end
      end
      n_cmp++;
      if ({busy, last_count} !== 3'b000) begin
         n_err++; $display("FAIL midreset_idle got %b want 000", {busy, last_count});
      end
   endtask

   initial begin
      rst = 1'b1;
      press = 1'b0;
      test_reset();
      test_single();
      test_double();
      test_late_second();
      test_triple(1'b0);
      test_triple(1'b1);
      test_boundary();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
